// File: rtl/seq_arith_unit.sv
// Sequential N-bit arithmetic unit: single-cycle add/sub, iterative shift-add multiply and restoring divide.
// Optional macro SEQ_ARITH_SIGNED_EN adds an sgn input for two's-complement mul/div.
module seq_arith_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
`ifdef SEQ_ARITH_SIGNED_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         cout,
  output logic         ovf,
  output logic         div_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [2*N-1:0] work_q, work_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   hi_q, hi_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic           sgn_en;
  logic [N:0]     sum, diff;
  logic           x_neg, y_neg;
  logic [N-1:0]   x_mag, y_mag;
  logic [2*N-1:0] work_nx, prod_fix;
  logic [N-1:0]   q_fix, r_fix;

  // Upper half accumulates the multiplicand while the multiplier shifts out of the lower half.
  function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] w, input logic [N-1:0] b);
    logic [N:0] s;
    s = w[0] ? ({1'b0, w[2*N-1:N]} + {1'b0, b}) : {1'b0, w[2*N-1:N]};
    return {s, w[N-1:1]};
  endfunction

  // Upper half is the partial remainder, lower half shifts dividend bits out and quotient bits in.
  function automatic logic [2*N-1:0] div_step(input logic [2*N-1:0] w, input logic [N-1:0] b);
    logic [N:0] sh, tr;
    sh = {w[2*N-1:N], w[N-1]};
    tr = sh - {1'b0, b};
    if (tr[N]) return {sh[N-1:0], w[N-2:0], 1'b0};
    else       return {tr[N-1:0], w[N-2:0], 1'b1};
  endfunction

`ifdef SEQ_ARITH_SIGNED_EN
  assign sgn_en = sgn;
`else
  assign sgn_en = 1'b0;
`endif

  assign sum   = {1'b0, x} + {1'b0, y};
  assign diff  = {1'b0, x} - {1'b0, y};
  assign x_neg = sgn_en & x[N-1];
  assign y_neg = sgn_en & y[N-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  assign work_nx  = is_div_q ? div_step(work_q, dsr_q) : mul_step(work_q, dsr_q);
  assign prod_fix = negq_q ? -work_nx : work_nx;
  assign q_fix    = negq_q ? -work_nx[N-1:0] : work_nx[N-1:0];
  assign r_fix    = negr_q ? -work_nx[2*N-1:N] : work_nx[2*N-1:N];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    dsr_d    = dsr_q;
    work_d   = work_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;

    case (state_q)
      S_CALC: begin
        work_d = work_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          if (is_div_q) begin
            lo_d   = q_fix;
            hi_d   = r_fix;
            cout_d = 1'b0;
          end else begin
            lo_d   = prod_fix[N-1:0];
            hi_d   = prod_fix[2*N-1:N];
            cout_d = |prod_fix[2*N-1:N];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          case (op)
            2'b00: begin
              state_d = S_DONE;
              done_d  = 1'b1;
              lo_d    = sum[N-1:0];
              hi_d    = '0;
              cout_d  = sum[N];
              ovf_d   = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
              dz_d    = 1'b0;
            end
            2'b01: begin
              state_d = S_DONE;
              done_d  = 1'b1;
              lo_d    = diff[N-1:0];
              hi_d    = '0;
              cout_d  = diff[N];
              ovf_d   = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
              dz_d    = 1'b0;
            end
            default: begin
              if (op[0] && (y == '0)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                lo_d    = '1;
                hi_d    = x;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                dz_d    = 1'b1;
              end else begin
                state_d  = S_CALC;
                busy_d   = 1'b1;
                cnt_d    = '0;
                is_div_d = op[0];
                dsr_d    = y_mag;
                work_d   = {{N{1'b0}}, x_mag};
                negq_d   = x_neg ^ y_neg;
                negr_d   = x_neg;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dsr_q    <= '0;
      work_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dsr_q    <= dsr_d;
      work_q   <= work_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign div_zero  = dz_q;

endmodule
